// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer: walks every neuron through
// one shared fp16 datapath per timestep, storing membrane potentials locally.
module lif_layer_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [15:0]      threshold,
    output logic             cur_req,
    output logic [IDX_W-1:0] cur_idx,
    input  logic             cur_valid,
    input  logic [15:0]      cur_data,
    output logic [15:0]      dp_potential,
    output logic [15:0]      dp_current,
    output logic [15:0]      dp_threshold,
    input  logic [15:0]      dp_sum,
    input  logic             dp_fire,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   spike_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMPUTE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      cur_latched;
    logic [IDX_W:0]   run_count;
    logic [15:0]      mem [NUM_NEURONS];

    assign dp_threshold = threshold;
    assign cur_idx      = idx;

    always_comb begin
        next_state   = state;
        cur_req      = 1'b0;
        dp_potential = 16'h0000;
        dp_current   = 16'h0000;
        busy         = (state != IDLE);
        done         = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                cur_req = 1'b1;
                if (cur_valid) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                dp_potential = mem[idx];
                dp_current   = cur_latched;
                next_state   = (idx == LAST_IDX) ? DONE : FETCH;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A firing neuron is reset to zero instead of keeping its summed potential.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cur_latched <= 16'h0000;
            run_count   <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike_count <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            state       <= next_state;
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        run_count <= '0;
                    end else if (clear) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            mem[i] <= 16'h0000;
                        end
                    end
                end
                FETCH: begin
                    if (cur_valid) begin
                        cur_latched <= cur_data;
                    end
                end
                COMPUTE: begin
                    mem[idx] <= dp_fire ? 16'h0000 : dp_sum;
                    if (dp_fire) begin
                        spike_valid <= 1'b1;
                        spike_idx   <= idx;
                        run_count   <= run_count + (IDX_W + 1)'(1);
                    end
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    spike_count <= run_count;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Randomised scoreboard bench for lif_layer_scheduler with a real-valued fp16
// LIF datapath (leak 0.5) and a per-cycle expected-output queue.
module tb_lif_layer_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam logic [15:0] THR = 16'h3C00;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          clear;
    logic [15:0]   threshold;
    logic          cur_req;
    logic [IW-1:0] cur_idx;
    logic          cur_valid;
    logic [15:0]   cur_data;
    logic [15:0]   dp_potential;
    logic [15:0]   dp_current;
    logic [15:0]   dp_threshold;
    logic [15:0]   dp_sum;
    logic          dp_fire;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic          busy;
    logic          done;
    logic [IW:0]   spike_count;

    lif_layer_scheduler #(.NUM_NEURONS(N), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .threshold(threshold), .cur_req(cur_req), .cur_idx(cur_idx),
        .cur_valid(cur_valid), .cur_data(cur_data),
        .dp_potential(dp_potential), .dp_current(dp_current),
        .dp_threshold(dp_threshold), .dp_sum(dp_sum), .dp_fire(dp_fire),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .busy(busy),
        .done(done), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real m;
        int  e;
        int  frac;
        if (r <= 0.0) return 16'h0000;
        m = r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        frac = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (frac >= 1024) begin frac = 0; e++; end
        if (e < -14) return 16'h0000;
        if (e > 15) return 16'h7C00;
        return {1'b0, 5'(e + 15), 10'(frac)};
    endfunction

    // Shared combinational datapath: sum = current + 0.5*potential, fire = sum > threshold.
    always_comb begin
        dp_sum  = r2h(h2r(dp_current) + h2r(dp_potential) * 0.5);
        dp_fire = h2r(dp_sum) > h2r(dp_threshold);
    end

    typedef struct {
        int            abs_cyc;
        bit            busy;
        bit            req;
        logic [IW-1:0] ridx;
        logic [15:0]   pot;
        logic [15:0]   cur;
        bit            spk;
        logic [IW-1:0] sidx;
        bit            dn;
        logic [IW:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] currents [N];
    int          stall_cfg [N];
    logic [15:0] model_pot [N];
    logic [IW:0] model_count;
    int          tests = 0;
    int          failed = 0;

    function automatic exp_t mk(int a, bit b, bit rq, int ri, logic [15:0] p,
                                logic [15:0] c, bit s, int si, bit d, logic [IW:0] n);
        exp_t e;
        e.abs_cyc = a; e.busy = b; e.req = rq; e.ridx = IW'(ri);
        e.pot = p; e.cur = c; e.spk = s; e.sidx = IW'(si); e.dn = d; e.cnt = n;
        return e;
    endfunction

    task automatic checkOutput(input exp_t e);
        bit bad = 0;
        tests++;
        if (busy !== e.busy) begin bad = 1; $display("[TB] FAIL busy @%0d: got %b, expected %b", cyc, busy, e.busy); end
        if (done !== e.dn) begin bad = 1; $display("[TB] FAIL done @%0d: got %b, expected %b", cyc, done, e.dn); end
        if (cur_req !== e.req) begin bad = 1; $display("[TB] FAIL cur_req @%0d: got %b, expected %b", cyc, cur_req, e.req); end
        if (e.req && cur_idx !== e.ridx) begin bad = 1; $display("[TB] FAIL cur_idx @%0d: got %0d, expected %0d", cyc, cur_idx, e.ridx); end
        if (dp_potential !== e.pot) begin bad = 1; $display("[TB] FAIL dp_potential @%0d: got %h, expected %h", cyc, dp_potential, e.pot); end
        if (dp_current !== e.cur) begin bad = 1; $display("[TB] FAIL dp_current @%0d: got %h, expected %h", cyc, dp_current, e.cur); end
        if (dp_threshold !== THR) begin bad = 1; $display("[TB] FAIL dp_threshold @%0d: got %h, expected %h", cyc, dp_threshold, THR); end
        if (spike_valid !== e.spk) begin bad = 1; $display("[TB] FAIL spike_valid @%0d: got %b, expected %b", cyc, spike_valid, e.spk); end
        if (e.spk && spike_idx !== e.sidx) begin bad = 1; $display("[TB] FAIL spike_idx @%0d: got %0d, expected %0d", cyc, spike_idx, e.sidx); end
        if (spike_count !== e.cnt) begin bad = 1; $display("[TB] FAIL spike_count @%0d: got %0d, expected %0d", cyc, spike_count, e.cnt); end
        if (bad) failed++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].abs_cyc < cyc) begin
                tests++;
                failed++;
                $display("[TB] FAIL schedule: entry for cycle %0d unchecked at %0d", exp_q[0].abs_cyc, cyc);
                void'(exp_q.pop_front());
            end else if (exp_q[0].abs_cyc == cyc) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    // Current source: stalls each fetch by the configured cycles, noise elsewhere.
    int stalled = 0;
    always @(negedge clk) begin
        if (cur_req) begin
            if (stalled < stall_cfg[cur_idx]) begin
                cur_valid = 1'b0;
                cur_data  = 16'($urandom);
                stalled++;
            end else begin
                cur_valid = 1'b1;
                cur_data  = currents[cur_idx];
            end
        end else begin
            stalled   = 0;
            cur_valid = 1'($urandom);
            cur_data  = 16'($urandom);
        end
    end

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    endtask

    task automatic applyStimulus(input int abort_cyc, input bit busy_noise, input bit clr_with_start);
        exp_t        gen[$];
        int          base;
        int          c;
        bit          pend;
        int          pidx;
        logic [IW:0] prev;
        logic [IW:0] run;
        logic [15:0] s;
        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        clear = clr_with_start;
        prev = model_count; run = '0; c = 1; pend = 0; pidx = 0;
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w <= stall_cfg[k]; w++) begin
                gen.push_back(mk(base + c, 1, 1, k, 16'h0, 16'h0, pend, pidx, 0, prev));
                pend = 0; c++;
            end
            gen.push_back(mk(base + c, 1, 0, 0, model_pot[k], currents[k], 0, 0, 0, prev));
            c++;
            s = r2h(h2r(currents[k]) + h2r(model_pot[k]) * 0.5);
            if (h2r(s) > h2r(THR)) begin
                model_pot[k] = 16'h0000; pend = 1; pidx = k; run++;
            end else begin
                model_pot[k] = s;
            end
        end
        gen.push_back(mk(base + c, 1, 0, 0, 16'h0, 16'h0, pend, pidx, 1, prev));
        c++;
        gen.push_back(mk(base + c, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, run));
        model_count = run;
        foreach (gen[i]) begin
            if (abort_cyc == 0 || gen[i].abs_cyc <= base + abort_cyc) exp_q.push_back(gen[i]);
        end
        if (abort_cyc > 0) begin
            exp_q.push_back(mk(base + abort_cyc + 1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, '0));
            foreach (model_pot[k]) model_pot[k] = 16'h0000;
            model_count = '0;
        end
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        if (busy_noise) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            start = 1'b1;
            clear = 1'b1;
            @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
        end
        if (abort_cyc > 0) begin
            while (cyc < base + abort_cyc) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        drain();
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        exp_q.push_back(mk(cyc + 1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, model_count));
        @(negedge clk);
        clear = 1'b0;
        foreach (model_pot[k]) model_pot[k] = 16'h0000;
        drain();
    endtask

    task automatic setAll(input logic [15:0] v);
        foreach (currents[k]) begin
            currents[k]  = v;
            stall_cfg[k] = 0;
        end
    endtask

    logic [15:0] pick [7];

    initial begin
        pick = '{16'h0000, 16'h3000, 16'h3400, 16'h3800, 16'h3A00, 16'h3C00, 16'h3E00};
        reset = 1'b1; start = 1'b0; clear = 1'b0; threshold = THR;
        setAll(16'h3A00);
        foreach (model_pot[k]) model_pot[k] = 16'h0000;
        model_count = '0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 3; i++)
            exp_q.push_back(mk(cyc + i, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, '0));
        @(negedge clk);
        reset = 1'b0;
        drain();

        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        stall_cfg[2] = 3;
        applyStimulus(0, 0, 0);
        stall_cfg[2] = 0;
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);
        applyStimulus(4, 0, 0);
        applyStimulus(0, 0, 0);
        doClear();
        applyStimulus(0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            foreach (currents[k]) begin
                currents[k]  = pick[$urandom_range(0, 6)];
                stall_cfg[k] = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 4) == 0) doClear();
            applyStimulus((t == 6) ? int'($urandom_range(1, 2 * N)) : 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
